// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO family.
package fifo_pkg;

    localparam int DEFAULT_DEPTH         = 16;
    localparam int DEFAULT_AFULL_MARGIN  = 2;
    localparam int DEFAULT_AEMPTY_THRESH = 2;

    // Ceiling log2, usable in parameter expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage array: synchronous write port, asynchronous read port.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and optional first-word-fall-through.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int AFULL_THRESH  = DEPTH - DEFAULT_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH,
    parameter int FWFT          = 0,
    localparam int ADDR_WIDTH   = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance uses last edge's flags only; no write/read bypass when full/empty.
    assign wr_acc = en & write & ~full;
    assign rd_acc = en & read & ~empty;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count - 1'b1;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (wr_acc & reset_n),
        .wr_addr(wr_ptr),
        .wr_data(data_in),
        .rd_addr(rd_ptr),
        .rd_data(ram_rd_data)
    );

    // Flags are computed from count_next so they line up with the new count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AFULL_THRESH == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (en) begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_CNT);
            almost_empty <= (count_next <= AEMPTY_CNT);
            almost_full  <= (count_next >= AFULL_CNT);
            if (write && full) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (read && empty) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // FWFT exposes the head word directly; standard mode registers it on a read.
    if (FWFT != 0) begin : g_fwft
        assign data_out = ram_rd_data;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= ram_rd_data;
            end
        end

        assign data_out = data_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: standard-mode instance driven from a
// queue model, plus a small FWFT instance exercised with directed vectors.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          en        = 1'b0;
    logic          write     = 1'b0;
    logic          read      = 1'b0;
    logic          clear_err = 1'b0;
    logic [DW-1:0] data_in   = '0;
    logic [DW-1:0] data_out;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0]    count;

    logic          f_write   = 1'b0;
    logic          f_read    = 1'b0;
    logic [DW-1:0] f_data_in = '0;
    logic [DW-1:0] f_data_out;
    logic          f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
    logic [4:0]    f_count;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] mon_exp;
    bit            m_ovf    = 1'b0;
    bit            m_unf    = 1'b0;
    bit            rd_valid = 1'b0;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .write(write), .data_in(data_in),
        .read(read), .data_out(data_out), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow), .clear_err(clear_err)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
        .clk(clk), .reset_n(reset_n), .en(en), .write(f_write), .data_in(f_data_in),
        .read(f_read), .data_out(f_data_out), .empty(f_empty), .full(f_full),
        .almost_empty(f_almost_empty), .almost_full(f_almost_full), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkFlags(input string name);
        int n;
        n = m_q.size();
        checkOutput({name, "_count"}, 32'(count), 32'(n));
        checkOutput({name, "_empty"}, 32'(empty), 32'(n == 0));
        checkOutput({name, "_full"}, 32'(full), 32'(n == DEPTH));
        checkOutput({name, "_aempty"}, 32'(almost_empty), 32'(n <= 2));
        checkOutput({name, "_afull"}, 32'(almost_full), 32'(n >= DEPTH - 2));
        checkOutput({name, "_ovf"}, 32'(overflow), 32'(m_ovf));
        checkOutput({name, "_unf"}, 32'(underflow), 32'(m_unf));
    endtask

    // One clock of stimulus; the queue model decides acceptance and pushes
    // each word a read should return onto the scoreboard queue.
    task automatic applyStimulus(input bit w, input bit r, input logic [DW-1:0] d,
                                 input bit ce = 1'b1, input bit clr = 1'b0);
        bit full_m, empty_m, wacc, racc;
        write     = w;
        read      = r;
        data_in   = d;
        en        = ce;
        clear_err = clr;
        full_m  = (m_q.size() == DEPTH);
        empty_m = (m_q.size() == 0);
        wacc    = ce & w & ~full_m;
        racc    = ce & r & ~empty_m;
        if (ce & w & full_m) m_ovf = 1'b1;
        else if (ce & clr) m_ovf = 1'b0;
        if (ce & r & empty_m) m_unf = 1'b1;
        else if (ce & clr) m_unf = 1'b0;
        if (racc) exp_q.push_back(m_q.pop_front());
        if (wacc) m_q.push_back(d);
        @(posedge clk);
        #1;
        rd_valid = racc;
    endtask

    task automatic resetDut(input int cycles, input bit w);
        rd_valid  = 1'b0;
        reset_n   = 1'b0;
        en        = 1'b1;
        write     = w;
        read      = 1'b0;
        clear_err = 1'b0;
        data_in   = 8'hEE;
        repeat (cycles) @(posedge clk);
        #1;
        m_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Monitor: whenever an accepted read should have produced data, compare it.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_underrun: output presented with no expected word at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("scoreboard_data", 32'(data_out), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting sync_fifo_param bench");

        resetDut(2, 1'b0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_aempty", 32'(almost_empty), 32'd1);
        checkOutput("reset_afull", 32'(almost_full), 32'd0);
        checkOutput("reset_data_out", 32'(data_out), 32'h00);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        checkOutput("reset_unf", 32'(underflow), 32'd0);
        checkOutput("reset_fwft_empty", 32'(f_empty), 32'd1);
        reset_n = 1'b1;
        write   = 1'b0;

        // Fill to full, then one rejected write of 0xFF
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i));
            if (i == 12) checkOutput("afull_at_13", 32'(almost_full), 32'd0);
            if (i == 13) checkOutput("afull_at_14", 32'(almost_full), 32'd1);
        end
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd16);
        applyStimulus(1'b1, 1'b0, 8'hFF);
        checkOutput("overflow_set", 32'(overflow), 32'd1);
        checkOutput("overflow_count", 32'(count), 32'd16);
        checkFlags("after_overflow");

        // Drain: scoreboard expects 0x00..0x0F in order
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("drain_last", 32'(data_out), 32'h0F);
        checkFlags("after_drain");

        // Simultaneous read+write at count 5
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h10 + i));
        checkFlags("count5");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h20 + i));
            checkOutput("simul_count", 32'(count), 32'd5);
        end
        checkFlags("after_simul");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Wrap-around, then underflow and error clear
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("underflow_set", 32'(underflow), 32'd1);
        checkOutput("underflow_hold_data", 32'(data_out), 32'h49);
        checkFlags("after_underflow");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("clear_ovf", 32'(overflow), 32'd0);
        checkOutput("clear_unf", 32'(underflow), 32'd0);

        // Hold with en=0, then reset mid-operation with write asserted
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 4; i++) applyStimulus(i[0], ~i[0], 8'hAA, 1'b0);
        checkOutput("hold_count", 32'(count), 32'd7);
        checkOutput("hold_ovf", 32'(overflow), 32'd0);
        checkOutput("hold_unf", 32'(underflow), 32'd0);
        checkFlags("after_hold");
        resetDut(1, 1'b1);
        checkOutput("midreset_count", 32'(count), 32'd0);
        checkOutput("midreset_empty", 32'(empty), 32'd1);
        reset_n = 1'b1;
        write   = 1'b0;
        en      = 1'b1;

        // FWFT: head word visible without a read
        f_write   = 1'b1;
        f_data_in = 8'hA5;
        @(posedge clk);
        #1;
        checkOutput("fwft_first_empty", 32'(f_empty), 32'd0);
        checkOutput("fwft_first_data", 32'(f_data_out), 32'hA5);
        f_data_in = 8'h5A;
        @(posedge clk);
        #1;
        f_write = 1'b0;
        f_read  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("fwft_second_data", 32'(f_data_out), 32'h5A);
        checkOutput("fwft_second_empty", 32'(f_empty), 32'd0);
        @(posedge clk);
        #1;
        f_read = 1'b0;
        checkOutput("fwft_final_empty", 32'(f_empty), 32'd1);
        checkOutput("fwft_final_count", 32'(f_count), 32'd0);

        @(posedge clk);
        #1;
        checkOutput("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
